// File: rtl/grid_sequencer_if.sv
// Instruction-memory read port plus the array-wide broadcast bundle of the
// grid sequencer. master = sequencer side, slave = memory/grid side.
interface grid_sequencer_if #(
   parameter int PC_W    = 8,
   parameter int SP_W    = 4,
   parameter int INSTR_W = 32
);
   logic               imem_rd_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] instruction;
   logic [PC_W-1:0]    next_program_counter;
   logic [SP_W-1:0]    next_stack_pointer;
   logic               global_enable;
   logic               diverge_consensus;

   modport master (
      output imem_rd_en, imem_addr, instruction, next_program_counter,
             next_stack_pointer, global_enable,
      input  imem_data, diverge_consensus
   );

   modport slave (
      input  imem_rd_en, imem_addr, instruction, next_program_counter,
             next_stack_pointer, global_enable,
      output imem_data, diverge_consensus
   );
endinterface

// File: rtl/grid_sequencer.sv
// Global control unit for the cellular-automaton array: fetches from a
// synchronous instruction memory, broadcasts each instruction with a one-cycle
// execute strobe, resolves consensus branches and keeps a return stack.
module grid_sequencer #(
   parameter int PC_W    = 8,
   parameter int SP_W    = 4,
   parameter int INSTR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   grid_sequencer_if.master    bus,
   output logic                halted,
   output logic                error,
   output logic [31:0]         instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_RESOLVE, S_HALT
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE  = 1;
   localparam logic [SP_W-1:0] SP_ONE  = 1;
   localparam logic [SP_W-1:0] SP_FULL = '1;
   localparam logic [31:0]     CNT_ONE = 1;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    npc_q, npc_d;
   logic               ge_q, ge_d;
   logic               halted_q, halted_d;
   logic               error_q, error_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               step_flag_q, step_flag_d;

   logic [PC_W-1:0]    stack_q [2**SP_W];
   logic               push_en;
   logic [PC_W-1:0]    push_data;

   logic [3:0]         opcode;
   logic [PC_W-1:0]    target;
   logic               complete;

   assign opcode = bus.imem_data[INSTR_W-1 -: 4];
   assign target = bus.imem_data[PC_W-1:0];

   // Next-state, decode and datapath updates for one sequencer cycle
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      instr_d     = instr_q;
      npc_d       = npc_q;
      ge_d        = 1'b0;
      halted_d    = halted_q;
      error_d     = error_q;
      cnt_d       = cnt_q;
      step_flag_d = step_flag_q;
      push_en     = 1'b0;
      push_data   = pc_q + PC_ONE;
      complete    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run || step) begin
               state_d     = S_FETCH;
               step_flag_d = step && !run;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            instr_d = bus.imem_data;
            npc_d   = pc_q;
            case (opcode)
               4'hC: begin
                  pc_d     = target;
                  complete = 1'b1;
               end
               4'hD: begin
                  ge_d    = 1'b1;
                  state_d = S_RESOLVE;
               end
               4'hE: begin
                  if (sp_q == SP_FULL) begin
                     error_d  = 1'b1;
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     push_en  = 1'b1;
                     sp_d     = sp_q + SP_ONE;
                     pc_d     = target;
                     complete = 1'b1;
                  end
               end
               4'hF: begin
                  if (bus.imem_data[INSTR_W-5]) begin
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else if (sp_q == '0) begin
                     error_d  = 1'b1;
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     sp_d     = sp_q - SP_ONE;
                     pc_d     = stack_q[sp_q - SP_ONE];
                     complete = 1'b1;
                  end
               end
               default: begin
                  ge_d     = 1'b1;
                  pc_d     = pc_q + PC_ONE;
                  complete = 1'b1;
               end
            endcase
         end
         S_RESOLVE: begin
            // Branch target still sits in the broadcast instruction register
            pc_d     = bus.diverge_consensus ? instr_q[PC_W-1:0] : pc_q + PC_ONE;
            complete = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (complete) begin
         cnt_d       = cnt_q + CNT_ONE;
         state_d     = run ? S_FETCH : S_IDLE;
         step_flag_d = 1'b0;
      end
   end

   // Control and architectural state, aborted immediately by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         sp_q        <= '0;
         instr_q     <= '0;
         npc_q       <= '0;
         ge_q        <= 1'b0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
         cnt_q       <= '0;
         step_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         instr_q     <= instr_d;
         npc_q       <= npc_d;
         ge_q        <= ge_d;
         halted_q    <= halted_d;
         error_q     <= error_d;
         cnt_q       <= cnt_d;
         step_flag_q <= step_flag_d;
      end
   end

   // Return-address stack; contents need no reset
   always_ff @(posedge clk) begin
      if (push_en) stack_q[sp_q] <= push_data;
   end

   assign bus.imem_rd_en           = (state_q == S_FETCH);
   assign bus.imem_addr            = pc_q;
   assign bus.instruction          = instr_q;
   assign bus.next_program_counter = npc_q;
   assign bus.next_stack_pointer   = sp_q;
   assign bus.global_enable        = ge_q;
   assign halted                   = halted_q;
   assign error                    = error_q;
   assign instr_count              = cnt_q;

endmodule

// File: tb/tb_grid_sequencer.sv
// Bench for grid_sequencer: instruction-level reference model with per-cycle
// output comparison, directed programs with literal expectations, then
// randomized programs with random run/step/consensus.
module tb_grid_sequencer;
   localparam int PC_W = 8, SP_W = 4, INSTR_W = 32;
   localparam logic [31:0] HALT_W = 32'hF800_0000;
   localparam logic [31:0] RET_W  = 32'hF000_0000;

   logic clk = 1'b0, rst = 1'b0, run = 1'b0, step = 1'b0, cons = 1'b0;
   logic halted, error;
   logic [31:0] instr_count;
   logic [31:0] mem [256];
   int checks = 0, errors = 0;

   grid_sequencer_if #(.PC_W(PC_W), .SP_W(SP_W), .INSTR_W(INSTR_W)) bus ();

   grid_sequencer #(.PC_W(PC_W), .SP_W(SP_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .bus(bus),
      .halted(halted), .error(error), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   assign bus.diverge_consensus = cons;

   always @(posedge clk) begin
      if (bus.imem_rd_en) bus.imem_data <= mem[bus.imem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state plus when each visible event is due
   logic [7:0]  m_pc, m_stack [16], last_fetch;
   logic [3:0]  m_sp;
   logic [31:0] m_cnt, exp_instr;
   logic [7:0]  exp_npc;
   logic        m_halt, m_err, ge_due, fetch_now, exec_now, resolve_now, idle;
   int          fetch_cnt, ge_cnt;

   always @(negedge clk) begin
      logic [31:0] w;
      logic        done;
      done = 1'b0;
      if (!rst) begin
         m_pc = 0; m_sp = 0; m_cnt = 0; m_halt = 0; m_err = 0;
         exp_instr = 0; exp_npc = 0; ge_due = 0; fetch_now = 0;
         exec_now = 0; resolve_now = 0; idle = 1; last_fetch = 0;
         fetch_cnt = 0; ge_cnt = 0;
      end else begin
         chk("imem_rd_en", {31'b0, bus.imem_rd_en}, {31'b0, fetch_now});
         if (fetch_now) chk("imem_addr", {24'b0, bus.imem_addr}, {24'b0, m_pc});
         chk("global_enable", {31'b0, bus.global_enable}, {31'b0, ge_due});
         chk("instruction", bus.instruction, exp_instr);
         chk("next_program_counter", {24'b0, bus.next_program_counter}, {24'b0, exp_npc});
         chk("next_stack_pointer", {28'b0, bus.next_stack_pointer}, {28'b0, m_sp});
         chk("instr_count", instr_count, m_cnt);
         chk("halted", {31'b0, halted}, {31'b0, m_halt});
         chk("error", {31'b0, error}, {31'b0, m_err});
         if (bus.imem_rd_en) begin last_fetch = bus.imem_addr; fetch_cnt++; end
         if (bus.global_enable) ge_cnt++;
         ge_due = 0;
         if (fetch_now) begin
            fetch_now = 0; exec_now = 1;
         end else if (exec_now) begin
            exec_now = 0;
            w = mem[m_pc]; exp_instr = w; exp_npc = m_pc;
            if (w[31:28] <= 4'hB) begin
               ge_due = 1; m_pc = m_pc + 8'd1; done = 1;
            end else if (w[31:28] == 4'hC) begin
               m_pc = w[7:0]; done = 1;
            end else if (w[31:28] == 4'hD) begin
               ge_due = 1; resolve_now = 1;
            end else if (w[31:28] == 4'hE) begin
               if (m_sp == 4'd15) begin m_halt = 1; m_err = 1; end
               else begin m_stack[m_sp] = m_pc + 8'd1; m_sp = m_sp + 4'd1; m_pc = w[7:0]; done = 1; end
            end else if (!w[27]) begin
               if (m_sp == 4'd0) begin m_halt = 1; m_err = 1; end
               else begin m_sp = m_sp - 4'd1; m_pc = m_stack[m_sp]; done = 1; end
            end else begin
               m_halt = 1;
            end
         end else if (resolve_now) begin
            resolve_now = 0;
            m_pc = cons ? exp_instr[7:0] : m_pc + 8'd1;
            done = 1;
         end else if (idle && (run || step)) begin
            idle = 0; fetch_now = 1;
         end
         if (done) begin
            m_cnt = m_cnt + 1;
            if (run) fetch_now = 1; else idle = 1;
         end
      end
   end

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) mem[i] = HALT_W;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      run = 0; step = 0; rst = 0;
      #1;
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_error", {31'b0, error}, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_ge", {31'b0, bus.global_enable}, 32'd0);
      chk("rst_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
      chk("rst_instr", bus.instruction, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1;
   endtask

   task automatic wait_halt(input int n);
      int k = 0;
      while (!halted && k < n) begin @(posedge clk); #1; k++; end
      chk("halt_reached", {31'b0, halted}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_prog(input int n);
      do_reset();
      @(posedge clk); #1 run = 1;
      wait_halt(n);
      run = 0;
   endtask

   task automatic step_once();
      @(posedge clk); #1 step = 1;
      @(posedge clk); #1 step = 0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      logic [3:0] op;
      // Two grid ops then HALT
      fill_halt(); mem[0] = 32'h1000_0000; mem[1] = 32'h2000_0000;
      run_prog(50);
      chk("A_count", instr_count, 32'd2);
      chk("A_error", {31'b0, error}, 32'd0);
      chk("A_ge_pulses", ge_cnt, 32'd2);
      // JMP 0x10
      fill_halt(); mem[0] = 32'hC000_0010;
      run_prog(50);
      chk("JMP_last_fetch", {24'b0, last_fetch}, 32'h10);
      chk("JMP_ge_pulses", ge_cnt, 32'd0);
      chk("JMP_count", instr_count, 32'd1);
      // BRC taken / not taken
      fill_halt(); mem[0] = 32'hD000_0020;
      cons = 1; run_prog(50);
      chk("BRC1_last_fetch", {24'b0, last_fetch}, 32'h20);
      chk("BRC1_count", instr_count, 32'd1);
      chk("BRC1_ge_pulses", ge_cnt, 32'd1);
      cons = 0; run_prog(50);
      chk("BRC0_last_fetch", {24'b0, last_fetch}, 32'h01);
      chk("BRC0_count", instr_count, 32'd1);
      // CALL 0x40 from address 3, RET back to 4
      fill_halt();
      for (int i = 0; i < 3; i++) mem[i] = 32'h0000_0000;
      mem[3] = 32'hE000_0040; mem[8'h40] = RET_W;
      run_prog(80);
      chk("CALL_count", instr_count, 32'd5);
      chk("CALL_sp", {28'b0, bus.next_stack_pointer}, 32'd0);
      chk("CALL_error", {31'b0, error}, 32'd0);
      chk("CALL_last_fetch", {24'b0, last_fetch}, 32'h04);
      // Stack overflow on the 16th nested CALL
      fill_halt();
      for (int i = 0; i < 16; i++) mem[i] = 32'hE000_0000 | (i + 1);
      run_prog(100);
      chk("OVF_count", instr_count, 32'd15);
      chk("OVF_error", {31'b0, error}, 32'd1);
      chk("OVF_sp", {28'b0, bus.next_stack_pointer}, 32'd15);
      // RET with empty stack
      fill_halt(); mem[0] = 32'h5000_0000; mem[1] = RET_W;
      run_prog(50);
      chk("UNF_count", instr_count, 32'd1);
      chk("UNF_error", {31'b0, error}, 32'd1);
      // Single steps with pc wrap 0xFF -> 0x00
      fill_halt(); mem[0] = 32'hC000_00FF; mem[8'hFF] = 32'h3000_0000;
      do_reset();
      step_once(); step_once(); step_once();
      chk("STEP_fetches", fetch_cnt, 32'd3);
      chk("STEP_count", instr_count, 32'd3);
      chk("STEP_last_fetch", {24'b0, last_fetch}, 32'h00);
      chk("STEP_halted", {31'b0, halted}, 32'd0);
      // Asynchronous reset while a branch is resolving
      fill_halt(); mem[0] = 32'h7000_0000; mem[1] = 32'hD000_0020;
      do_reset();
      @(posedge clk); #1 run = 1;
      k = 0;
      while (!(bus.global_enable && bus.instruction[31:28] == 4'hD) && k < 20) begin
         @(posedge clk); #1; k++;
      end
      chk("RSV_reached", {31'b0, bus.global_enable}, 32'd1);
      chk("RSV_pre_count", instr_count, 32'd1);
      rst = 0; #1;
      chk("RSV_ge", {31'b0, bus.global_enable}, 32'd0);
      chk("RSV_count", instr_count, 32'd0);
      chk("RSV_instr", bus.instruction, 32'd0);
      chk("RSV_npc", {24'b0, bus.next_program_counter}, 32'd0);
      chk("RSV_addr", {24'b0, bus.imem_addr}, 32'd0);
      run = 0;
      repeat (2) @(posedge clk);
      #3 rst = 1;
      // Randomized programs with random run/step/consensus
      for (int p = 0; p < 15; p++) begin
         for (int i = 0; i < 256; i++) begin
            k = $urandom_range(99);
            if (k < 50) op = 4'($urandom_range(11));
            else if (k < 60) op = 4'hC;
            else if (k < 75) op = 4'hD;
            else if (k < 87) op = 4'hE;
            else op = 4'hF;
            mem[i] = {op, (k >= 97), 19'($urandom), 8'($urandom)};
         end
         do_reset();
         for (int c = 0; c < 300 && !halted; c++) begin
            @(posedge clk); #1;
            run  = ($urandom_range(99) < 85);
            step = ($urandom_range(9) == 0);
            cons = $urandom_range(1);
         end
         run = 0; step = 0;
         repeat (3) @(posedge clk);
         #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/grid_sequencer.md
Name: grid_sequencer

Overview:
- Global control unit for the cellular-automaton core array.
- Fetches instructions from a synchronous instruction memory and broadcasts each one to every cell, along with program counter, stack pointer and a one-cycle enable strobe.
- Resolves branches from the array-wide consensus bit and maintains a return-address stack for call/return.
- Sits between instruction memory and the grid; host-side run/step/halt controls.

Parameters:
PC_W, 8, program counter width; instruction memory holds 2^PC_W words
SP_W, 4, stack pointer width; return stack depth 2^SP_W
INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1 -: 4]

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
run  in  1  level; free-running execution while high
step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
imem_rd_en  out  1  instruction memory read strobe
imem_addr  out  PC_W  instruction memory address; data returns next cycle
imem_data  in  INSTR_W  instruction memory read data
instruction  out  INSTR_W  instruction broadcast to all cells
next_program_counter  out  PC_W  PC of the issued instruction
next_stack_pointer  out  SP_W  current stack pointer
global_enable  out  1  one-cycle cell execute strobe
diverge_consensus  in  1  AND of all cell branch votes; valid the cycle after a BRC issue
halted  out  1  sticky; HALT executed or error
error  out  1  sticky; stack overflow or underflow
instr_count  out  32  retired-instruction counter, wraps

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; pc=0, sp=0.
  - instruction=0, global_enable=0, imem_rd_en=0.
  - halted=0, error=0, instr_count=0.
  - Return stack contents are undefined.
- States: IDLE, FETCH, EXEC, RESOLVE, HALT.
- IDLE:
  - run=1 or step=1 -> FETCH; run has priority when both are high.
  - step is latched as a single-shot flag.
- FETCH: imem_rd_en=1, imem_addr=pc -> EXEC.
- EXEC: instruction<=imem_data, next_program_counter=pc. Decode on the opcode:
  - 0x0-0xB grid op: global_enable=1; pc<=pc+1.
  - 0xC JMP: pc<=imem_data[PC_W-1:0]; global_enable=0.
  - 0xD BRC: global_enable=1 -> RESOLVE.
  - 0xE CALL:
    - If sp==2^SP_W-1: error<=1, halted<=1 -> HALT.
    - Otherwise stack[sp]<=pc+1; sp<=sp+1; pc<=target; global_enable=0.
  - 0xF with bit INSTR_W-5 = 0, RET:
    - If sp==0: error<=1, halted<=1 -> HALT.
    - Otherwise sp<=sp-1; pc<=stack[sp-1]; global_enable=0.
  - 0xF with bit INSTR_W-5 = 1, HALT: halted<=1 -> HALT.
- RESOLVE: sample diverge_consensus.
  - 1: pc<=target.
  - 0: pc<=pc+1.
  - global_enable=0.
- Completion of EXEC (non-BRC) or RESOLVE:
  - instr_count+=1; HALT and error instructions do not count.
  - Next state is FETCH if run=1, else IDLE; the step flag is cleared.
- Latency: 2 cycles per instruction; BRC takes 3.
- instruction holds its value until the next EXEC.
- global_enable is high exactly one cycle per grid op or BRC.
- Arithmetic: pc wraps modulo 2^PC_W (0xFF+1=0x00); instr_count wraps modulo 2^32.
- run deasserted mid-instruction: the current instruction completes, then IDLE.
- step while not in IDLE: ignored.
- HALT: all strobes low; exits only via reset.
- Reset mid-operation: immediate abort; no partial pc/sp update survives.
- next_stack_pointer reflects sp after the update, from the cycle following CALL/RET EXEC.

Test Plan:
- Reset, run=1, imem = {0x1..., 0x2..., HALT} -> global_enable pulses in cycles 2 and 4; halted=1 after cycle 6; instr_count=2; error=0.
- JMP 0x10 at address 0 -> next FETCH imem_addr=0x10; global_enable stays 0 during JMP EXEC.
- BRC target 0x20, consensus=1 -> pc=0x20; repeat with consensus=0 -> pc=1; instr_count increments once per BRC.
- CALL 0x40 at address 3, RET at 0x40 -> sp goes 0->1->0, fetch resumes at address 4; 16 nested CALLs (SP_W=4) -> error=1, halted=1 on the 16th.
- RET with sp=0 -> error=1, halted=1, instr_count unchanged; run=0 with step pulse from IDLE -> exactly one instruction, then IDLE.
- Grid op at pc=0xFF -> next fetch at 0x00; rst asserted during RESOLVE -> all outputs at reset values asynchronously, before the next clock edge.
